pmod_io_ctrl: RTL and testbench

Parametrised PMOD button/LED controller, the successor to the fixed 4-button/4-LED PMOD glue on the board wrappers. It synchronises and debounces N asynchronous button inputs and latches press/release events with an interrupt. It drives N LEDs in per-channel off/on/blink/PWM modes. It sits between a board's `pio` pins and the SoC I/O bus as a small register slave (4 × 32-bit words).

---
 rtl/pmod_io_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pmod_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_io_ctrl.sv
// pmod_io_ctrl: PMOD button/LED controller with a 4-word register slave.
// Buttons pass through a 2-FF synchroniser and a per-channel debouncer.
// Stable edges latch press/release flags that raise IRQ.
// LEDs are driven per channel as off, on, shared blink or shared PWM.
module pmod_io_ctrl #(
  parameter int N         = 4,
  parameter int DB_CYCLES = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int PWM_DIV   = 1
) (
  input  logic         CLK,
  input  logic         RESN,
  input  logic         WR,
  input  logic [1:0]   ADDR,
  input  logic [31:0]  WDATA,
  output logic [31:0]  RDATA,
  input  logic [N-1:0] BTN_IN,
  output logic [N-1:0] LED_OUT,
  output logic         IRQ
);

  typedef enum logic [1:0] {
    REG_BTN     = 2'd0,
    REG_EVT     = 2'd1,
    REG_LEDMODE = 2'd2,
    REG_CTRL    = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_e;

  localparam logic [15:0] DB_LAST    = 16'(DB_CYCLES - 1);
  localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
  localparam logic [7:0]  PWM_LAST   = 8'(PWM_DIV - 1);

  reg_addr_e      addr;
  logic [N-1:0]   sync1, sync2;
  logic [N-1:0]   stable, stable_d;
  logic [15:0]    db_cnt [N];
  logic [N-1:0]   evt_press, evt_release;
  logic [N-1:0]   clr_press, clr_release;
  logic           evt_wr;
  logic [2*N-1:0] led_mode, led_mode_nxt;
  logic [7:0]     duty, duty_nxt;
  logic           irq_en, irq_en_nxt;
  logic [25:0]    blink_cnt;
  logic           blink_phase;
  logic [7:0]     pwm_pre, pwm_cnt;
  logic           pwm_on;
  logic [N-1:0]   led_nxt;
  logic           unused_wdata;

  assign addr         = reg_addr_e'(ADDR);
  assign evt_wr       = WR && (addr == REG_EVT);
  assign clr_press    = evt_wr ? WDATA[N-1:0]  : '0;
  assign clr_release  = evt_wr ? WDATA[16 +: N] : '0;
  assign pwm_on       = (pwm_cnt < duty_nxt);
  assign unused_wdata = ^WDATA;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would collapse sync1/sync2 into one stage.
    if (!RESN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= BTN_IN;
      sync2 <= sync1;
    end
  end

  // Debouncer: count while input differs from stable state, adopt it at DB_LAST.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      stable <= '0;
      // NOTE: the counter array is ordinary flops, not a RAM, so it is reset
      // explicitly; a reset mid-debounce must discard any partial count.
      for (int i = 0; i < N; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Event flags: stable edges set, W1C clears; a set beats a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      stable_d    <= '0;
      evt_press   <= '0;
      evt_release <= '0;
    end else begin
      stable_d    <= stable;
      evt_press   <= (evt_press   & ~clr_press)   | (stable & ~stable_d);
      evt_release <= (evt_release & ~clr_release) | (~stable & stable_d);
    end
  end

  // Next value of the RW registers, also used so LEDs follow a write at once.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    led_mode_nxt = led_mode;
    duty_nxt     = duty;
    irq_en_nxt   = irq_en;
    if (WR && (addr == REG_LEDMODE)) led_mode_nxt = WDATA[2*N-1:0];
    if (WR && (addr == REG_CTRL)) begin
      duty_nxt   = WDATA[7:0];
      irq_en_nxt = WDATA[8];
    end
  end

  // RW register storage and the registered interrupt.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      led_mode <= '0;
      duty     <= '0;
      irq_en   <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      led_mode <= led_mode_nxt;
      duty     <= duty_nxt;
      irq_en   <= irq_en_nxt;
      IRQ      <= irq_en & ((|evt_press) | (|evt_release));
    end
  end

  // Shared blink timebase; the phase comes out of reset high.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 26'd1;
    end
  end

  // Shared PWM counter advancing once every PWM_DIV cycles, wrapping 255->0.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      pwm_pre <= '0;
      pwm_cnt <= '0;
    end else if (pwm_pre == PWM_LAST) begin
      pwm_pre <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pwm_pre <= pwm_pre + 8'd1;
    end
  end

  // Per-channel LED source selection from the (possibly just written) mode.
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < N; i++) begin
      case (led_mode_e'(led_mode_nxt[2*i +: 2]))
        LED_OFF:   led_nxt[i] = 1'b0;
        LED_ON:    led_nxt[i] = 1'b1;
        LED_BLINK: led_nxt[i] = blink_phase;
        LED_PWM:   led_nxt[i] = pwm_on;
      endcase
    end
  end

  // Registered LED drive.
  always_ff @(posedge CLK) begin
    if (!RESN) LED_OUT <= '0;
    else       LED_OUT <= led_nxt;
  end

  // Side-effect-free read mux; unused bits read 0.
  always_comb begin
    RDATA = '0;
    case (addr)
      REG_BTN:     RDATA[N-1:0] = stable;
      REG_EVT: begin
        RDATA[N-1:0]  = evt_press;
        RDATA[16 +: N] = evt_release;
      end
      REG_LEDMODE: RDATA[2*N-1:0] = led_mode;
      REG_CTRL: begin
        RDATA[7:0] = duty;
        RDATA[8]   = irq_en;
      end
    endcase
  end

endmodule

// File: tb/tb_pmod_io_ctrl.sv
// Directed self-checking bench for pmod_io_ctrl.
// dut4: N=4, DB_CYCLES=8, BLINK_DIV=4, PWM_DIV=1.
// dut8: N=8, DB_CYCLES=8, BLINK_DIV=4, PWM_DIV=3.
module tb_pmod_io_ctrl;

  localparam logic [1:0] A_BTN = 2'd0, A_EVT = 2'd1, A_LED = 2'd2, A_CTRL = 2'd3;

  logic clk = 1'b0;
  logic resn;
  always #5 clk = ~clk;

  logic        wr4, irq4;
  logic [1:0]  addr4;
  logic [31:0] wdata4, rdata4;
  logic [3:0]  btn4, led4;

  logic        wr8, irq8;
  logic [1:0]  addr8;
  logic [31:0] wdata8, rdata8;
  logic [7:0]  btn8, led8;

  int tests = 0;
  int fails = 0;
  int cyc;

  pmod_io_ctrl #(.N(4), .DB_CYCLES(8), .BLINK_DIV(4), .PWM_DIV(1)) dut4 (
    .CLK(clk), .RESN(resn), .WR(wr4), .ADDR(addr4), .WDATA(wdata4),
    .RDATA(rdata4), .BTN_IN(btn4), .LED_OUT(led4), .IRQ(irq4)
  );

  pmod_io_ctrl #(.N(8), .DB_CYCLES(8), .BLINK_DIV(4), .PWM_DIV(3)) dut8 (
    .CLK(clk), .RESN(resn), .WR(wr8), .ADDR(addr8), .WDATA(wdata8),
    .RDATA(rdata8), .BTN_IN(btn8), .LED_OUT(led8), .IRQ(irq8)
  );

  // Edges since the last reset edge; anchors the blink/PWM reference.
  always @(posedge clk) begin
    if (!resn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input bit big, input logic [1:0] a, input logic [31:0] d);
    if (big) begin wr8 = 1'b1; addr8 = a; wdata8 = d; end
    else     begin wr4 = 1'b1; addr4 = a; wdata4 = d; end
    @(posedge clk);
    #1;
    wr4 = 1'b0;
    wr8 = 1'b0;
  endtask

  task automatic rd_reg(input bit big, input logic [1:0] a, output logic [31:0] d);
    if (big) addr8 = a; else addr4 = a;
    #1;
    d = big ? rdata8 : rdata4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  exp_led;
    int highs, lows, period, m;
    bit prev, found;

    resn = 1'b0;
    wr4 = 1'b0; addr4 = '0; wdata4 = '0; btn4 = 4'($urandom);
    wr8 = 1'b0; addr8 = '0; wdata8 = '0; btn8 = 8'($urandom);
    tick(2);

    // Power-on reset state
    check("por_led4", led4, 0);
    check("por_irq4", irq4, 0);
    check("por_led8", led8, 0);
    check("por_irq8", irq8, 0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(0, 2'(a), r); check("por_reg4", r, 0);
      rd_reg(1, 2'(a), r); check("por_reg8", r, 0);
    end
    resn = 1'b1;
    btn4 = '0;
    btn8 = '0;
    tick(24);
    rd_reg(0, A_EVT, r); check("por_no_evt4", r, 0);
    rd_reg(1, A_EVT, r); check("por_no_evt8", r, 0);

    // 7-cycle glitch is rejected
    btn4[2] = 1'b1;
    tick(7);
    btn4[2] = 1'b0;
    tick(12);
    rd_reg(0, A_BTN, r); check("glitch_btn", r, 0);
    rd_reg(0, A_EVT, r); check("glitch_evt", r, 0);

    // Held press: BTN after 10 cycles, EVT one later
    btn4[2] = 1'b1;
    tick(9);
    rd_reg(0, A_BTN, r); check("press_btn_c9", r, 0);
    tick(1);
    rd_reg(0, A_BTN, r); check("press_btn_c10", r, 32'h4);
    rd_reg(0, A_EVT, r); check("press_evt_c10", r, 0);
    tick(1);
    rd_reg(0, A_EVT, r); check("press_evt_c11", r, 32'h0000_0004);
    check("press_irq_disabled", irq4, 0);

    // Release
    btn4[2] = 1'b0;
    tick(12);
    rd_reg(0, A_BTN, r); check("release_btn", r, 0);
    rd_reg(0, A_EVT, r); check("release_evt", r, 32'h0004_0004);

    // IRQ enable and W1C
    wr_reg(0, A_CTRL, 32'h100);
    check("irq_en_lag", irq4, 0);
    tick(1);
    check("irq_en_on", irq4, 1);
    rd_reg(0, A_CTRL, r); check("ctrl_rd", r, 32'h100);
    wr_reg(0, A_EVT, 32'h4);
    rd_reg(0, A_EVT, r); check("w1c_press", r, 32'h0004_0000);
    check("w1c_irq_still", irq4, 1);
    wr_reg(0, A_EVT, 32'h4_0000);
    rd_reg(0, A_EVT, r); check("w1c_release", r, 0);
    check("w1c_irq_lag", irq4, 1);
    tick(1);
    check("w1c_irq_off", irq4, 0);

    // Set and clear on the same bit in the same cycle: set wins
    btn4[2] = 1'b1;
    tick(10);
    rd_reg(0, A_EVT, r); check("collide_pre", r, 0);
    wr_reg(0, A_EVT, 32'h4);
    rd_reg(0, A_EVT, r); check("collide_set_wins", r, 32'h4);
    tick(1);
    check("collide_irq", irq4, 1);
    btn4[2] = 1'b0;
    tick(12);
    wr_reg(0, A_EVT, 32'hFFFF_FFFF);
    rd_reg(0, A_EVT, r); check("clear_all", r, 0);

    // Read-only BTN, unused bits read 0
    wr_reg(0, A_BTN, 32'hFFFF_FFFF);
    rd_reg(0, A_BTN, r); check("btn_ro", r, 0);
    wr_reg(0, A_LED, 32'hFFFF_FFFF);
    rd_reg(0, A_LED, r); check("ledmode_width4", r, 32'hFF);
    wr_reg(0, A_CTRL, 32'hFFFF_FFFF);
    rd_reg(0, A_CTRL, r); check("ctrl_width", r, 32'h1FF);
    wr_reg(1, A_LED, 32'hFFFF_FFFF);
    rd_reg(1, A_LED, r); check("ledmode_width8", r, 32'hFFFF);
    wr_reg(1, A_LED, 32'h0);
    wr_reg(0, A_CTRL, 32'h0);

    // N=8: simultaneous press and release on all channels
    btn8 = 8'hFF;
    tick(10);
    rd_reg(1, A_BTN, r); check("n8_btn", r, 32'hFF);
    rd_reg(1, A_EVT, r); check("n8_evt_pre", r, 0);
    tick(1);
    rd_reg(1, A_EVT, r); check("n8_press", r, 32'h0000_00FF);
    btn8 = 8'h00;
    tick(12);
    rd_reg(1, A_EVT, r); check("n8_release", r, 32'h00FF_00FF);

    // PWM_DIV=3: period 768 cycles, 384 high at duty 0x80
    wr_reg(1, A_CTRL, 32'h80);
    wr_reg(1, A_LED, 32'h3);
    prev = led8[0];
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1);
      if (!prev && led8[0]) found = 1'b1;
      prev = led8[0];
    end
    check("pwm3_rise_found", 32'(found), 1);
    highs = 1;
    period = 0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1);
      period++;
      if (!prev && led8[0]) found = 1'b1;
      else highs += int'(led8[0]);
      prev = led8[0];
    end
    check("pwm3_period", 32'(period), 768);
    check("pwm3_high", 32'(highs), 384);

    // Reset mid-debounce with LEDs lit
    wr_reg(0, A_LED, 32'h55);
    wr_reg(0, A_CTRL, 32'h1FF);
    check("pre_reset_led", led4, 4'hF);
    btn4[1] = 1'b1;
    tick(5);
    resn = 1'b0;
    btn4 = 4'($urandom);
    tick(2);
    check("rst_led4", led4, 0);
    check("rst_irq4", irq4, 0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(0, 2'(a), r); check("rst_reg4", r, 0);
    end
    resn = 1'b1;
    btn4 = '0;
    highs = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      rd_reg(0, A_EVT, r);
      if (r != 0) highs++;
    end
    check("rst_no_spurious_evt", 32'(highs), 0);

    // LED modes: ch0 PWM duty 0x40, ch1 off, ch2 on, ch3 blink
    wr_reg(0, A_CTRL, 32'h40);
    wr_reg(0, A_LED, 32'h93);
    highs = 0;
    for (int i = 0; i < 520; i++) begin
      m = cyc - 1;
      exp_led[0] = ((m % 256) < 64);
      exp_led[1] = 1'b0;
      exp_led[2] = 1'b1;
      exp_led[3] = (((m / 4) % 2) == 0);
      check("led_modes", led4, exp_led);
      if (i < 256) highs += int'(led4[0]);
      tick(1);
    end
    check("pwm_duty40_high", 32'(highs), 64);

    // Duty 0: never high
    wr_reg(0, A_CTRL, 32'h0);
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      highs += int'(led4[0]);
      tick(1);
    end
    check("pwm_duty0", 32'(highs), 0);

    // Duty 0xFF: low exactly one step in 256
    wr_reg(0, A_CTRL, 32'hFF);
    lows = 0;
    for (int i = 0; i < 256; i++) begin
      lows += int'(!led4[0]);
      tick(1);
    end
    check("pwm_duty255_low", 32'(lows), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
